// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: mode codes, op words,
// op-word field positions, the holding-register state encoding and
// the multi-beat classification helper.
package alu_ctrl_pkg;

  // Mode codes carried on id_mode
  localparam int unsigned MODE_ADD  = 0;
  localparam int unsigned MODE_RSB  = 1;
  localparam int unsigned MODE_OP2  = 2;
  localparam int unsigned MODE_OP3  = 3;
  localparam int unsigned MODE_OP4  = 4;
  localparam int unsigned MODE_OP5  = 5;
  localparam int unsigned MODE_OP6  = 6;
  localparam int unsigned MODE_OP7  = 7;
  localparam int unsigned MODE_OP8  = 8;
  localparam int unsigned MODE_OP9  = 9;
  localparam int unsigned MODE_OP10 = 10;
  localparam int unsigned MODE_OP11 = 11;
  localparam int unsigned MODE_SEQ  = 12;
  localparam int unsigned MODE_OP13 = 13;
  localparam int unsigned MODE_OP14 = 14;
  localparam int unsigned MODE_MUL  = 15;

  // Op words: {Cin, oper[3:0], invA, invB, sign}
  localparam logic [7:0] OP_IDLE = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h21;
  localparam logic [7:0] OP_RSB  = 8'hA5;
  localparam logic [7:0] OP_OP2  = 8'h38;
  localparam logic [7:0] OP_OP3  = 8'h2A;
  localparam logic [7:0] OP_OP4  = 8'h00;
  localparam logic [7:0] OP_OP5  = 8'h08;
  localparam logic [7:0] OP_OP6  = 8'h10;
  localparam logic [7:0] OP_OP7  = 8'h18;
  localparam logic [7:0] OP_OP8  = 8'h01;
  localparam logic [7:0] OP_OP9  = 8'h30;
  localparam logic [7:0] OP_OP10 = 8'h60;
  localparam logic [7:0] OP_OP11 = 8'h40;
  localparam logic [7:0] OP_SEQ  = 8'h48;
  localparam logic [7:0] OP_OP13 = 8'h50;
  localparam logic [7:0] OP_OP14 = 8'h58;
  localparam logic [7:0] OP_MUL  = 8'h69;

  // Field positions inside the op word
  localparam int CIN     = 7;
  localparam int OPER_HI = 6;
  localparam int OPER_LO = 3;
  localparam int INVA    = 2;
  localparam int INVB    = 1;
  localparam int SIGN    = 0;

  // Holding-register occupancy
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } state_t;

  // True for the mode that occupies the ALU for several beats
  function automatic logic is_multi(input logic [31:0] mode);
    return (mode == 32'(MODE_MUL));
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational {en, mode} -> ALU op word lookup. A disabled ALU or a
// mode outside the 16-entry table yields the IDLE op.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int MODE_W = 4
) (
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  output logic [7:0]        op
);

  logic [31:0] mode_ext;

  // Table lookup; anything not listed falls back to IDLE
  always_comb begin
    mode_ext = 32'(mode);
    op       = OP_IDLE;
    if (en) begin
      case (mode_ext)
        MODE_ADD:  op = OP_ADD;
        MODE_RSB:  op = OP_RSB;
        MODE_OP2:  op = OP_OP2;
        MODE_OP3:  op = OP_OP3;
        MODE_OP4:  op = OP_OP4;
        MODE_OP5:  op = OP_OP5;
        MODE_OP6:  op = OP_OP6;
        MODE_OP7:  op = OP_OP7;
        MODE_OP8:  op = OP_OP8;
        MODE_OP9:  op = OP_OP9;
        MODE_OP10: op = OP_OP10;
        MODE_OP11: op = OP_OP11;
        MODE_SEQ:  op = OP_SEQ;
        MODE_OP13: op = OP_OP13;
        MODE_OP14: op = OP_OP14;
        MODE_MUL:  op = OP_MUL;
        default:   op = OP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control stage between decode and execute. Decodes {en, mode} into
// an op word and holds it in an output register with a valid/ready
// handshake. The multiply mode is held for MUL_CYCLES beats while decode
// is stalled; flush squashes whatever is held and drops any offered op.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MODE_W     = 4,
  parameter int MUL_CYCLES = 16,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_en,
  input  logic [MODE_W-1:0] id_mode,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [7:0]        ex_op,
  output logic [CNT_W-1:0]  ex_cnt,
  output logic              ex_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);
  localparam logic             MULTI_OK = (MUL_CYCLES > 1);

  state_t     state;
  logic [7:0] dec_op;
  logic       accept;
  logic       retire;
  logic       load_multi;

  alu_op_decode #(
    .MODE_W (MODE_W)
  ) u_decode (
    .en   (id_en),
    .mode (id_mode),
    .op   (dec_op)
  );

  // Handshake and status derived from the held state
  always_comb begin
    ex_valid   = (state != EMPTY);
    busy       = (state == MULTI);
    ex_last    = (state == SINGLE) || ((state == MULTI) && (ex_cnt == LAST_CNT));
    stall_id   = ex_valid && !(ex_ready && ex_last);
    accept     = id_valid && !stall_id && !flush;
    retire     = ex_valid && ex_ready && ex_last;
    load_multi = id_en && is_multi(32'(id_mode)) && MULTI_OK;
  end

  // Holding register FSM: rst > flush > accept/retire > beat advance > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      ex_op  <= OP_IDLE;
      ex_cnt <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      ex_cnt <= '0;
    end else if (accept) begin
      state  <= load_multi ? MULTI : SINGLE;
      ex_op  <= dec_op;
      ex_cnt <= '0;
    end else if (retire) begin
      state  <= EMPTY;
      ex_cnt <= '0;
    end else if ((state == MULTI) && ex_ready && !ex_last) begin
      ex_cnt <= ex_cnt + 1'b1;
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, sequencing ALU control stage. It sits between decode and execute.
- It decodes {en, mode} into an 8-bit ALU op word and holds it in an ID/EX-style output register with a valid/ready handshake.
- New modes: 15, an iterative signed multiply that occupies the ALU for MUL_CYCLES beats with back-pressure to decode; and 12 (SEQ), now a distinct decode.
- Flush support for branch and exception squash.

Parameters:
- MODE_W, 4, width of the mode field; modes at or above 16 decode as IDLE.
- MUL_CYCLES, 16, beats for mode 15. Legal range 1..64. A value of 1 makes mode 15 behave as a single-beat op.
- CNT_W, 6, beat counter width; must satisfy 2^CNT_W >= MUL_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- id_valid  in  1  decode offers an op
- id_en  in  1  ALU enable; 0 forces the IDLE op
- id_mode  in  MODE_W  ALU work mode
- flush  in  1  squash the held op
- ex_ready  in  1  execute consumes the current beat
- stall_id  out  1  decode must hold; combinational
- ex_valid  out  1  ex_op is valid
- ex_op  out  8  {Cin, oper[3:0], invA, invB, sign}
- ex_cnt  out  CNT_W  current beat index of the held op
- ex_last  out  1  current beat is the final beat of the held op
- busy  out  1  a multi-beat op is in progress

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Decode (hex op word):
  - en=0: 01
  - m0: 21
  - m1: A5
  - m2: 38
  - m3: 2A
  - m4: 00
  - m5: 08
  - m6: 10
  - m7: 18
  - m8: 01
  - m9: 30
  - m10: 60
  - m11: 40
  - m12: 48
  - m13: 50
  - m14: 58
  - m15: 69
  - other: 01
- States:
  - EMPTY: ex_valid=0.
  - SINGLE: holds a one-beat op.
  - MULTI: holds mode 15 with MUL_CYCLES>1.
- Combinational outputs:
  - stall_id = ex_valid & ~(ex_ready & ex_last).
  - ex_last = (state==SINGLE) | (state==MULTI & ex_cnt==MUL_CYCLES-1).
  - busy = (state==MULTI).
- Accept: when id_valid & ~stall_id & ~flush, the decoded op is loaded into ex_op at the clock edge and ex_cnt is set to 0.
  - Next state is MULTI for en=1, m15, MUL_CYCLES>1; otherwise SINGLE.
  - Latency: exactly 1 cycle from accept to ex_valid.
- Retire: when ex_valid & ex_ready & ex_last and no new accept occurs, the next state is EMPTY.
  - Back-to-back accept is allowed in the same cycle as retire, giving full throughput of one single-beat op per cycle.
- MULTI beats: each cycle with ex_ready=1 and not ex_last, ex_cnt increments by 1. With ex_ready=0, ex_cnt and ex_op hold.
  - ex_cnt never wraps; it is reset to 0 on accept.
- When ex_valid=0, ex_op holds its last value. When EMPTY, ex_op holds 01 after reset.
- Flush: at the next edge, state=EMPTY and ex_cnt=0. An offered op in the same cycle is dropped and is not accepted.
  - Flush mid-MULTI aborts the multiply.
  - Flush while EMPTY has no effect.
- Priority: rst > flush > retire/accept > hold.
- Reset values: ex_valid=0, ex_op=8'h01, ex_cnt=0, busy=0, stall_id=0, ex_last=0.
  - rst mid-MULTI aborts immediately.
- id_valid=0 while EMPTY leaves the state at EMPTY and ex_op unchanged.

Decomposition:
- Package alu_ctrl_pkg holds:
  - mode constants MODE_ADD..MODE_MUL
  - op-word constants OP_ADD..OP_MUL and OP_IDLE=8'h01
  - field positions: CIN=7, OPER=6:3, INVA=2, INVB=1, SIGN=0
  - state enum {EMPTY, SINGLE, MULTI}
  - function is_multi(mode)
- One sub-module, alu_op_decode: purely combinational {en, mode} -> op word lookup, instantiated once.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, then rst=0 with idle inputs -> ex_valid=0, ex_op=01, stall_id=0, busy=0.
- ex_ready=1; offer m0, m1, m12, m13 on consecutive cycles -> ex_op=21, A5, 48, 50 on cycles 1-4, ex_valid continuous, stall_id never asserted.
- MUL_CYCLES=16; offer m15 then m2 -> ex_op=69 for 16 beats with ex_cnt 0..15; stall_id=1 for the first 15 beats; ex_op=38 on the following cycle.
- During m15, drop ex_ready for 3 cycles at ex_cnt=5 -> ex_cnt holds at 5; total occupancy 19 cycles.
- Flush at ex_cnt=7 of m15 with m3 offered in the same cycle -> next cycle EMPTY, ex_cnt=0; m3 not accepted; m3 re-offered and accepted, giving ex_op=2A.
- Sweep en=0 with all modes, and en=1 with mode 8 -> ex_op=01 every time, single beat; rst asserted mid-MULTI -> all outputs at reset values next cycle.
